// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer:
// op encodings, FSM state type and default datapath width.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of either the shift-add multiply or the
// restoring divide, on a {hi, lo} style double-width accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           ge;

  // Multiply adds into the upper half then shifts right;
  // divide shifts {rem, quot} left and subtracts when it fits.
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (acc[0] ? {1'b0, opnd} : '0);
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge    = trial >= {1'b0, opnd};
    diff  = ge ? trial - {1'b0, opnd} : trial;
    if (is_div) begin
      acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], ge};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Generates the EX stall while an operation is in flight.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               is_sgn;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .opnd     (opnd_q),
    .is_div   (op_q[1]),
    .acc_next (step_acc)
  );

  // Operand magnitudes and final sign-corrected results.
  always_comb begin
    is_sgn = ~op[0];
    rs_neg = is_sgn & rs_val[WIDTH-1];
    rt_neg = is_sgn & rt_val[WIDTH-1];
    rs_mag = rs_neg ? -rs_val : rs_val;
    rt_mag = rt_neg ? -rt_val : rt_val;
    prod   = neg_q ? -acc_q : acc_q;
    quo    = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                    : acc_q[2*WIDTH-1:WIDTH];
  end

  // FSM next-state, datapath loads and HI/LO commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_RUN;
          cnt_d   = 5'd31;
          op_d    = op;
          neg_d   = rs_neg ^ rt_neg;
          rneg_d  = rs_neg;
          dz_d    = op[1] && (rt_val == '0);
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, rs_mag};
            opnd_d = rt_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, rt_mag};
            opnd_d = rs_mag;
          end
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (op_q[1]) begin
          hi_d = rem;
          lo_d = dz_q ? {WIDTH{1'b1}} : quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy_q & (hilo_rd | start);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer.
// Expected HI/LO pairs are queued at issue, popped at done.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hilo_rd;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  muldiv_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .hilo_rd (hilo_rd),
    .flush   (flush),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [63:0] exp);
    sb_q.push_back(exp);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    tick();
    start  = 1'b0;
  endtask

  task automatic finish_op(input string tag);
    int n;
    logic [63:0] exp;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd33);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      check({tag, "_hilo"}, {hi, lo}, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] exp);
    issue(o, a, b, exp);
    finish_op(tag);
  endtask

  initial begin
    int pulses;
    logic [63:0] exp;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    rs_val  = '0;
    rt_val  = '0;
    hilo_rd = 1'b0;
    flush   = 1'b0;
    tick();
    tick();
    reset   = 1'b0;
    hilo_rd = 1'b1;
    #1;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_ctl", {61'd0, busy, done, stall}, 64'd0);
    hilo_rd = 1'b0;
    tick();

    run_op("mult55", 2'b00, 32'd5, 32'd5, 64'd25);
    run_op("mult_n3x7", 2'b00, 32'hFFFF_FFFD, 32'd7,
           64'hFFFF_FFFF_FFFF_FFEB);
    run_op("multu", 2'b01, 32'hFFFF_FFFD, 32'd7,
           64'h0000_0006_FFFF_FFEB);
    run_op("div28_10", 2'b10, 32'd28, 32'd10,
           {32'd8, 32'd2});
    run_op("div_n7_2", 2'b10, 32'hFFFF_FFF9, 32'd2,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           {32'd0, 32'h8000_0000});
    run_op("divu_z", 2'b11, 32'd10, 32'd0,
           {32'd10, 32'hFFFF_FFFF});
    run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'd16,
           {32'd15, 32'h0FFF_FFFF});

    // stall window, ignored start, back-to-back accept
    issue(2'b00, 32'd2, 32'd3, 64'd6);
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (k == 2) hilo_rd = 1'b1;
      if (k == 5) begin
        start  = 1'b1;
        op     = 2'b11;
        rs_val = 32'd100;
        rt_val = 32'd7;
      end
      if (k == 6) start = 1'b0;
      #1;
      if (k >= 2 && k <= 32) check("stall_hi", 64'(stall), 64'd1);
      if (k == 32) check("done_early", 64'(done), 64'd0);
    end
    check("done_pulse", 64'(done), 64'd1);
    check("stall_done", 64'(stall), 64'd0);
    exp = sb_q.pop_front();
    check("ign_hilo", {hi, lo}, exp);
    hilo_rd = 1'b0;
    issue(2'b01, 32'd4, 32'd9, 64'd36);
    check("done_1cyc", 64'(done), 64'd0);
    finish_op("b2b");

    // flush mid-run
    run_op("mult55b", 2'b00, 32'd5, 32'd5, 64'd25);
    issue(2'b10, 32'd100, 32'd3, 64'd0);
    void'(sb_q.pop_back());
    for (int k = 1; k <= 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_busy", 64'(busy), 64'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) pulses++;
      tick();
    end
    check("fl_nodone", 64'(pulses), 64'd0);
    check("fl_hilo", {hi, lo}, 64'd25);

    // flush together with start in idle
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b00;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("fl_start", 64'(busy), 64'd0);

    // asynchronous reset mid-run
    issue(2'b00, 32'd7, 32'd7, 64'd49);
    void'(sb_q.pop_back());
    for (int k = 0; k < 6; k++) tick();
    hilo_rd = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("ar_hilo", {hi, lo}, 64'd0);
    check("ar_ctl", {62'd0, busy, stall}, 64'd0);
    tick();
    reset   = 1'b0;
    hilo_rd = 1'b0;
    tick();
    run_op("post_rst", 2'b10, 32'd9, 32'd4, {32'd1, 32'd2});
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
